// File: rtl/seq_det_pkg.sv
// Shared constants and helpers for the parametrised serial sequence detector.
package seq_det_pkg;

  localparam logic [3:0] DEF_PATTERN = 4'b1011;
  localparam int         DEF_CNT_W   = 8;

  // Width needed to count fill levels 0..len inclusive.
  function automatic int fill_w(input int len);
    return $clog2(len + 1);
  endfunction

endpackage

// File: rtl/seq_det_param_if.sv
// Stream, pattern-load and status signals of seq_det_param, bundled with master/slave views.
interface seq_det_param_if #(
  parameter int LEN   = 4,
  parameter int CNT_W = 8
);

  // PI is consumed on every rising clk edge where in_valid=1 and load=0; there is
  // no backpressure, so the detector accepts one bit per such cycle unconditionally.
  logic             in_valid;
  logic             PI;
  logic             ovl;
  logic             load;
  logic [LEN-1:0]   pat_in;
  logic             cnt_clr;
  logic             PO;
  logic [CNT_W-1:0] match_cnt;
  logic             busy;

  modport master (
    output in_valid, PI, ovl, load, pat_in, cnt_clr,
    input  PO, match_cnt, busy
  );

  modport slave (
    input  in_valid, PI, ovl, load, pat_in, cnt_clr,
    output PO, match_cnt, busy
  );

endinterface

// File: rtl/seq_match_counter.sv
// Saturating up-counter with a synchronous clear that wins over increment.
module seq_match_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/seq_det_param.sv
// Serial sequence detector with a runtime-loadable LEN-bit pattern, selectable overlap
// and a registered match pulse. Define SEQ_DET_CNT_EN to build the saturating match counter.
module seq_det_param
  import seq_det_pkg::*;
#(
  parameter int             LEN     = 4,
  parameter logic [LEN-1:0] DEF_PAT = LEN'(DEF_PATTERN),
  parameter int             CNT_W   = DEF_CNT_W
) (
  input  logic           clk,
  input  logic           reset,
  seq_det_param_if.slave bus
);

  localparam int FW = fill_w(LEN);
  typedef logic [FW-1:0] fill_t;
  localparam fill_t LEN_F = fill_t'(LEN);

  logic [LEN-1:0] pattern, pattern_d;
  logic [LEN-1:0] history, history_d;
  logic [LEN-1:0] hist_shift;
  fill_t          fill, fill_d, fill_inc;
  logic           po, po_d;
  logic           match;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pattern <= DEF_PAT;
      history <= '0;
      fill    <= '0;
      po      <= 1'b0;
    end else begin
      pattern <= pattern_d;
      history <= history_d;
      fill    <= fill_d;
      po      <= po_d;
    end
  end

  // Bits older than the fill level are stale, so a match also needs a full window.
  always_comb begin
    hist_shift = {history[LEN-2:0], bus.PI};
    fill_inc   = (fill == LEN_F) ? LEN_F : fill_t'(fill + 1'b1);
    match      = (hist_shift == pattern) && (fill >= fill_t'(LEN_F - 1'b1));
  end

  always_comb begin
    pattern_d = pattern;
    history_d = history;
    fill_d    = fill;
    po_d      = 1'b0;
    if (bus.load) begin
      pattern_d = bus.pat_in;
      history_d = '0;
      fill_d    = '0;
    end else if (bus.in_valid) begin
      history_d = hist_shift;
      po_d      = match;
      fill_d    = (match && !bus.ovl) ? '0 : fill_inc;
    end
  end

  assign bus.PO   = po;
  assign bus.busy = (fill < LEN_F);

`ifdef SEQ_DET_CNT_EN
  seq_match_counter #(
    .W (CNT_W)
  ) u_match_counter (
    .clk   (clk),
    .reset (reset),
    .inc   (po_d),
    .clr   (bus.cnt_clr),
    .count (bus.match_cnt)
  );
`else
  logic unused_cnt_clr;
  assign unused_cnt_clr = bus.cnt_clr;
  assign bus.match_cnt  = '0;
`endif

endmodule

// File: tb/tb_seq_det_param.sv
// Directed bench for seq_det_param: a LEN=4 instance and a LEN=2/CNT_W=2 instance,
// each checked every cycle against a bit-count model, plus literal expectations.
module tb_seq_det_param;

`ifdef SEQ_DET_CNT_EN
  localparam int CNT_ON = 1;
`else
  localparam int CNT_ON = 0;
`endif

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  seq_det_param_if #(.LEN(4), .CNT_W(8)) bus_a ();
  seq_det_param_if #(.LEN(2), .CNT_W(2)) bus_b ();

  seq_det_param #(.LEN(4), .DEF_PAT(4'b1011), .CNT_W(8)) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_a.slave)
  );

  seq_det_param #(.LEN(2), .DEF_PAT(2'b11), .CNT_W(2)) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_b.slave)
  );

  // Model: count of bits accepted since the window was last emptied, plus the recent bits.
  typedef struct {
    int pat;
    int n;
    int recent;
    int po;
    int cnt;
  } mstate_t;

  mstate_t ma, mb;

  function automatic mstate_t model_init(input int pat);
    mstate_t r;
    r.pat = pat; r.n = 0; r.recent = 0; r.po = 0; r.cnt = 0;
    return r;
  endfunction

  function automatic mstate_t model_next(input mstate_t s, input int len, input int cmax,
                                         input bit ld, input bit v, input bit pi,
                                         input bit o, input bit clr, input int patin);
    mstate_t r;
    bit      m;
    r = s;
    r.po = 0;
    if (ld) begin
      r.pat = patin;
      r.n   = 0;
    end else if (v) begin
      r.recent = ((s.recent * 2) + int'(pi)) % (1 << len);
      m        = (s.n + 1 >= len) && (r.recent == s.pat);
      r.n      = (s.n + 1 > len) ? len : s.n + 1;
      r.po     = int'(m);
      if (m && !o) r.n = 0;
    end
    if (CNT_ON == 0) r.cnt = 0;
    else if (clr) r.cnt = 0;
    else if ((r.po == 1) && (s.cnt < cmax)) r.cnt = s.cnt + 1;
    return r;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      ma <= model_init(4'b1011);
      mb <= model_init(2'b11);
    end else begin
      ma <= model_next(ma, 4, 255, bus_a.load, bus_a.in_valid, bus_a.PI, bus_a.ovl,
                       bus_a.cnt_clr, int'(bus_a.pat_in));
      mb <= model_next(mb, 2, 3, bus_b.load, bus_b.in_valid, bus_b.PI, bus_b.ovl,
                       bus_b.cnt_clr, int'(bus_b.pat_in));
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      check("model_po_a",   32'(bus_a.PO),        ma.po);
      check("model_busy_a", 32'(bus_a.busy),      int'(ma.n < 4));
      check("model_cnt_a",  32'(bus_a.match_cnt), ma.cnt);
      check("model_po_b",   32'(bus_b.PO),        mb.po);
      check("model_busy_b", 32'(bus_b.busy),      int'(mb.n < 2));
      check("model_cnt_b",  32'(bus_b.match_cnt), mb.cnt);
    end
  end

  // Drivers: set inputs just after an edge, wait for the sampling edge, return idle.
  task automatic step_a(input bit v, input bit pi, input bit ld = 1'b0,
                        input logic [3:0] pat = 4'h0, input bit clr = 1'b0);
    bus_a.in_valid = v;
    bus_a.PI       = pi;
    bus_a.load     = ld;
    bus_a.pat_in   = pat;
    bus_a.cnt_clr  = clr;
    @(posedge clk);
    #1;
    bus_a.in_valid = 1'b0;
    bus_a.load     = 1'b0;
    bus_a.cnt_clr  = 1'b0;
  endtask

  task automatic step_b(input bit v, input bit pi, input bit clr = 1'b0);
    bus_b.in_valid = v;
    bus_b.PI       = pi;
    bus_b.cnt_clr  = clr;
    @(posedge clk);
    #1;
    bus_b.in_valid = 1'b0;
    bus_b.cnt_clr  = 1'b0;
  endtask

  task automatic run_stream(input string tag, input logic [15:0] bits, input int n,
                            input logic [15:0] exp_po, input logic [15:0] exp_busy);
    for (int i = 0; i < n; i++) begin
      step_a(1'b1, bits[n-1-i]);
      check($sformatf("%s_po_bit%0d", tag, i + 1), 32'(bus_a.PO), 32'(exp_po[n-1-i]));
      check($sformatf("%s_busy_bit%0d", tag, i + 1), 32'(bus_a.busy), 32'(exp_busy[n-1-i]));
    end
  endtask

  initial begin
    reset = 1'b1;
    bus_a.in_valid = 1'b0; bus_a.PI = 1'b0; bus_a.ovl = 1'b1; bus_a.load = 1'b0;
    bus_a.pat_in = '0; bus_a.cnt_clr = 1'b0;
    bus_b.in_valid = 1'b0; bus_b.PI = 1'b0; bus_b.ovl = 1'b1; bus_b.load = 1'b0;
    bus_b.pat_in = '0; bus_b.cnt_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check("reset_po",   32'(bus_a.PO),        0);
    check("reset_busy", 32'(bus_a.busy),      1);
    check("reset_cnt",  32'(bus_a.match_cnt), 0);

    // Overlapping detection of the default pattern.
    bus_a.ovl = 1'b1;
    run_stream("ovl1", 16'b1011011, 7, 16'b0001001, 16'b1110000);
    check("ovl1_cnt", 32'(bus_a.match_cnt), 2 * CNT_ON);
    step_a(1'b0, 1'b1);
    check("idle_po", 32'(bus_a.PO), 0);

    // Non-overlapping: reload the same pattern to empty the window, clear the count.
    step_a(1'b0, 1'b0, 1'b1, 4'b1011, 1'b1);
    check("clr_cnt",   32'(bus_a.match_cnt), 0);
    check("load_busy", 32'(bus_a.busy),      1);
    bus_a.ovl = 1'b0;
    run_stream("ovl0", 16'b1011011, 7, 16'b0001000, 16'b1111111);
    check("ovl0_cnt", 32'(bus_a.match_cnt), 1 * CNT_ON);

    // Runtime-loaded pattern.
    bus_a.ovl = 1'b1;
    step_a(1'b0, 1'b0, 1'b1, 4'b0110);
    check("load_po", 32'(bus_a.PO), 0);
    run_stream("pat0110", 16'b0110110, 7, 16'b0001001, 16'b1110000);
    check("pat0110_cnt", 32'(bus_a.match_cnt), 3 * CNT_ON);

    // Gaps in in_valid between the second and third bits.
    step_a(1'b0, 1'b0, 1'b1, 4'b1011);
    step_a(1'b1, 1'b1);
    step_a(1'b1, 1'b0);
    for (int g = 0; g < 3; g++) begin
      step_a(1'b0, 1'b1);
      check($sformatf("gap_po_%0d", g), 32'(bus_a.PO), 0);
    end
    step_a(1'b1, 1'b1);
    check("gap_po_bit3", 32'(bus_a.PO), 0);
    step_a(1'b1, 1'b1);
    check("gap_po_bit4", 32'(bus_a.PO), 1);
    check("gap_cnt", 32'(bus_a.match_cnt), 4 * CNT_ON);

    // Mid-pattern asynchronous reset must restore the default pattern.
    step_a(1'b0, 1'b0, 1'b1, 4'b0110);
    step_a(1'b1, 1'b1);
    step_a(1'b1, 1'b0);
    step_a(1'b1, 1'b1);
    reset = 1'b1;
    #1;
    check("async_po",   32'(bus_a.PO),        0);
    check("async_cnt",  32'(bus_a.match_cnt), 0);
    check("async_busy", 32'(bus_a.busy),      1);
    #1;
    reset = 1'b0;
    run_stream("after_rst", 16'b1011, 4, 16'b0001, 16'b1110);
    check("after_rst_cnt", 32'(bus_a.match_cnt), 1 * CNT_ON);

    // LEN=2, CNT_W=2: five back-to-back matches of 11 saturate at 3.
    bus_b.ovl = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step_b(1'b1, 1'b1);
      check($sformatf("sat_po_bit%0d", i + 1), 32'(bus_b.PO), int'(i >= 1));
    end
    check("sat_cnt", 32'(bus_b.match_cnt), 3 * CNT_ON);
    step_b(1'b1, 1'b1, 1'b1);
    check("clr_match_po",  32'(bus_b.PO),        1);
    check("clr_match_cnt", 32'(bus_b.match_cnt), 0);
    step_b(1'b1, 1'b1);
    check("post_clr_cnt", 32'(bus_b.match_cnt), 1 * CNT_ON);
    step_b(1'b0, 1'b1);
    check("b_idle_po", 32'(bus_b.PO), 0);

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_det_param.md
Name: seq_det_param

Overview:
Parametrised serial sequence detector, successor to the fixed 4-bit overlapping detector.
- Pattern length is a parameter; the pattern itself is loadable at runtime.
- Overlapping or non-overlapping detection is selected per run.
- Moore-style registered output, plus an optional saturating match counter.
- Sits in the lab datapath wherever a serial bit stream needs framing or sync-word detection.

Parameters:
LEN, 4, pattern length in bits (2..16).
DEF_PAT, 4'b1011, reset value of the pattern register (LEN bits, MSB is the first bit received).
CNT_W, 8, width of the match counter.

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
in_valid  input  1  PI is sampled only when 1
PI  input  1  serial data bit
ovl  input  1  1 = overlapping detection, 0 = non-overlapping
load  input  1  load pat_in into the pattern register
pat_in  input  LEN  new pattern, MSB first
cnt_clr  input  1  synchronous clear of match_cnt
PO  output  1  registered match pulse
match_cnt  output  CNT_W  saturating count of matches
busy  output  1  1 while fill < LEN (window not yet full)

Behaviour:
Reset:
- Clock and reset are fixed: one clock, clk; reset is asynchronous and active-high.
- On reset: pattern register = DEF_PAT, history = 0, fill = 0, PO = 0, match_cnt = 0, busy = 1.

State:
- History shift register, LEN bits.
- Fill counter, 0..LEN, width $clog2(LEN+1).
- Pattern register.
- PO flop.

Accept cycle (in_valid=1, load=0):
- history <= {history[LEN-2:0], PI}.
- fill <= min(fill+1, LEN).
- Match condition: the new history equals the pattern AND fill+1 >= LEN.

Match:
- PO <= 1 on the edge that samples the final pattern bit.
- PO is therefore high for exactly the cycle after that edge (latency 1, Moore).

PO timing:
- PO is 0 in every other cycle, including idle cycles (in_valid=0).
- Back-to-back matches produce consecutive PO highs.

Overlap mode:
- ovl=1: after a match, history and fill are kept, so overlapping matches fire.
- ovl=0: after a match, fill <= 0 (history may keep stale bits; it is gated by fill).
- ovl is sampled every accept cycle; changing it mid-stream takes effect on the next accept.

in_valid=0:
- History and fill hold.
- PO <= 0.

Load:
- load=1 has priority over in_valid.
- Pattern <= pat_in; history <= 0; fill <= 0; PO <= 0; PI is ignored that cycle.
- match_cnt is unaffected.

busy:
- busy = (fill < LEN), combinational from the fill flop.

Counter:
- match_cnt increments on each cycle where PO is set.
- It saturates at 2^CNT_W-1.
- cnt_clr=1 zeroes it; a simultaneous increment is lost (clear wins).

Mid-operation reset:
- Asynchronous reset returns everything to the reset values immediately, including the pattern, which reverts to DEF_PAT.

Optional Feature:
SEQ_DET_CNT_EN
- Defined: match counter and cnt_clr logic are instantiated as described.
- Undefined: the match_cnt port remains and is tied to 0; cnt_clr is ignored; no counter flops are generated.

Decomposition:
Package seq_det_pkg:
- Default pattern constant (4'b1011).
- Default CNT_W.
- Helper function for fill-counter width ($clog2(LEN+1)).

Sub-module seq_match_counter:
- Parametrised saturating counter with inc/clr, CNT_W.
- Instantiated inside the SEQ_DET_CNT_EN guard.

Test Plan:
- Reset, DEF_PAT=1011, ovl=1, stream 1,0,1,1,0,1,1 with in_valid=1 -> PO pulses the cycle after bit 4 and after bit 7; match_cnt=2.
- Same stream with ovl=0 -> single PO pulse after bit 4; match_cnt=1.
- load=1 with pat_in=0110, then stream 0,1,1,0,1,1,0 with ovl=1 -> PO after bits 4 and 7; busy=1 for the first 3 accepts after load.
- Stream 1,0,1,1 with in_valid dropped for 3 cycles between bits 2 and 3 -> PO still pulses one cycle after bit 4 is accepted, and PO stays 0 during the gaps.
- CNT_W=2, 5 consecutive overlapping matches of pattern 11 -> match_cnt saturates at 3; cnt_clr asserted in the same cycle as a match -> match_cnt=0.
- Assert reset asynchronously mid-pattern (after 1,0,1) -> PO=0, match_cnt=0, and the pattern reverts to 1011; the next 1,0,1,1 detects after bit 4.
